// File: rtl/ec_point_add.sv
// ec_point_add
// Sequential elliptic-curve point adder over GF(p) for y^2 = x^3 + a*x + b.
// Computes R = P + Q, or 2P when P == Q. The slope denominator is inverted
// with Fermat's little theorem, den^(p-2), using square-and-multiply.
// The point at infinity is reported as (0,0).
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid            one-cycle request strobe, only sampled in IDLE
//   in_Px, in_Py        point P
//   in_Qx, in_Qy        point Q
//   in_prime            odd prime modulus p (3..61 for DATA_W = 6)
//   in_a                curve coefficient a
//   out_valid           one-cycle result strobe, DATA_W + 4 edges after accept
//   out_Rx, out_Ry      result point, zero whenever out_valid is low
module ec_point_add #(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_Px,
    input  logic [DATA_W-1:0] in_Py,
    input  logic [DATA_W-1:0] in_Qx,
    input  logic [DATA_W-1:0] in_Qy,
    input  logic [DATA_W-1:0] in_prime,
    input  logic [DATA_W-1:0] in_a,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_Rx,
    output logic [DATA_W-1:0] out_Ry
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NUM,
        S_INV,
        S_SLOPE,
        S_RX,
        S_RY,
        S_OUT
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] px, py, qx, qy, p, a;
    logic [DATA_W-1:0] num, den, acc, e, s, rx;
    logic              inf;
    logic [CNT_W-1:0]  cnt;

    // (x * y) mod m, product formed at full 2*DATA_W width
    function automatic logic [DATA_W-1:0] mod_mul(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y,
                                                   input logic [DATA_W-1:0] m);
        logic [2*DATA_W-1:0] prod;
        prod = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
        return DATA_W'(prod % {{DATA_W{1'b0}}, m});
    endfunction

    // (x - y) mod m as (x + m - y) mod m; x, y < m keeps this non-negative
    function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y,
                                                   input logic [DATA_W-1:0] m);
        logic [DATA_W:0] t;
        t = {1'b0, x} + {1'b0, m} - {1'b0, y};
        return DATA_W'(t % {1'b0, m});
    endfunction

    function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y,
                                                   input logic [DATA_W-1:0] m);
        logic [DATA_W:0] t;
        t = {1'b0, x} + {1'b0, y};
        return DATA_W'(t % {1'b0, m});
    endfunction

    // (3*x^2 + a) mod m, reduced after each step so nothing exceeds 2*DATA_W bits
    function automatic logic [DATA_W-1:0] tangent_num(input logic [DATA_W-1:0] x,
                                                       input logic [DATA_W-1:0] ca,
                                                       input logic [DATA_W-1:0] m);
        logic [DATA_W-1:0]   sq;
        logic [2*DATA_W-1:0] t;
        sq = mod_mul(x, x, m);
        t  = {{DATA_W{1'b0}}, sq} + {{DATA_W{1'b0}}, sq} + {{DATA_W{1'b0}}, sq};
        t  = t % {{DATA_W{1'b0}}, m};
        t  = t + {{DATA_W{1'b0}}, ca};
        return DATA_W'(t % {{DATA_W{1'b0}}, m});
    endfunction

    logic              dbl;
    logic [DATA_W-1:0] num_calc, den_calc, acc_sq, acc_step, s_calc, rx_calc, ry_calc;

    assign dbl      = (px == qx) && (py == qy);
    assign num_calc = dbl ? tangent_num(px, a, p) : mod_sub(qy, py, p);
    assign den_calc = dbl ? mod_add(py, py, p)    : mod_sub(qx, px, p);
    // Exponent is shifted left each INV cycle, so its MSB is always the current bit
    assign acc_sq   = mod_mul(acc, acc, p);
    assign acc_step = e[DATA_W-1] ? mod_mul(acc_sq, den, p) : acc_sq;
    assign s_calc   = mod_mul(num, acc, p);
    assign rx_calc  = mod_sub(mod_sub(mod_mul(s, s, p), px, p), qx, p);
    assign ry_calc  = mod_sub(mod_mul(s, mod_sub(px, rx, p), p), py, p);

    // Control and datapath. The result is loaded into the output registers
    // on the RY edge so out_valid is high exactly while the FSM sits in OUT;
    // every other cycle the outputs fall back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            px        <= '0;
            py        <= '0;
            qx        <= '0;
            qy        <= '0;
            p         <= '0;
            a         <= '0;
            num       <= '0;
            den       <= '0;
            acc       <= '0;
            e         <= '0;
            s         <= '0;
            rx        <= '0;
            inf       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_Rx    <= '0;
            out_Ry    <= '0;
        end else begin
            out_valid <= 1'b0;
            out_Rx    <= '0;
            out_Ry    <= '0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        px    <= in_Px;
                        py    <= in_Py;
                        qx    <= in_Qx;
                        qy    <= in_Qy;
                        p     <= in_prime;
                        a     <= in_a;
                        state <= S_NUM;
                    end
                end
                S_NUM: begin
                    num   <= num_calc;
                    den   <= den_calc;
                    inf   <= (den_calc == '0);
                    acc   <= DATA_W'(1);
                    e     <= p - DATA_W'(2);
                    cnt   <= CNT_W'(DATA_W - 1);
                    state <= S_INV;
                end
                S_INV: begin
                    acc <= acc_step;
                    e   <= e << 1;
                    if (cnt == '0) begin
                        state <= S_SLOPE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SLOPE: begin
                    s     <= s_calc;
                    state <= S_RX;
                end
                S_RX: begin
                    rx    <= rx_calc;
                    state <= S_RY;
                end
                S_RY: begin
                    out_valid <= 1'b1;
                    out_Rx    <= inf ? '0 : rx;
                    out_Ry    <= inf ? '0 : ry_calc;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ec_point_add.sv
// tb_ec_point_add
// Self-checking bench for ec_point_add. Expected points come from a plain
// integer reference model that finds the slope inverse by search.
module tb_ec_point_add;

    localparam int DW = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a;
    logic          out_valid;
    logic [DW-1:0] out_Rx, out_Ry;

    int n_checks = 0;
    int n_pass   = 0;

    ec_point_add #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_Px    (in_Px),
        .in_Py    (in_Py),
        .in_Qx    (in_Qx),
        .in_Qy    (in_Qy),
        .in_prime (in_prime),
        .in_a     (in_a),
        .out_valid(out_valid),
        .out_Rx   (out_Rx),
        .out_Ry   (out_Ry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int md(input int v, input int m);
        return ((v % m) + m) % m;
    endfunction

    // Reference: textbook chord/tangent rule, inverse found by exhaustive search
    task automatic ref_add(input int px, input int py, input int qx, input int qy,
                           input int p, input int a, output int rx, output int ry);
        int num, den, inv, s;
        if (px == qx && py == qy) begin
            num = md(3 * px * px + a, p);
            den = md(2 * py, p);
        end else begin
            num = md(qy - py, p);
            den = md(qx - px, p);
        end
        if (den == 0) begin
            rx = 0;
            ry = 0;
        end else begin
            inv = 0;
            for (int i = 1; i < p; i++) if (md(den * i, p) == 1) inv = i;
            s  = md(num * inv, p);
            rx = md(s * s - px - qx, p);
            ry = md(s * (px - rx) - py, p);
        end
    endtask

    task automatic drive_idle_inputs();
        in_valid = 1'b0;
        in_Px    = DW'($urandom);
        in_Py    = DW'($urandom);
        in_Qx    = DW'($urandom);
        in_Qy    = DW'($urandom);
        in_prime = DW'($urandom);
        in_a     = DW'($urandom);
    endtask

    task automatic drive_req(input int px, input int py, input int qx, input int qy,
                             input int p, input int a);
        in_valid = 1'b1;
        in_Px    = DW'(px);
        in_Py    = DW'(py);
        in_Qx    = DW'(qx);
        in_Qy    = DW'(qy);
        in_prime = DW'(p);
        in_a     = DW'(a);
    endtask

    // Present a request so that the next rising edge (E0) samples it
    task automatic issue(input int px, input int py, input int qx, input int qy,
                         input int p, input int a);
        @(negedge clk);
        drive_req(px, py, qx, qy, p, a);
        @(posedge clk);
        #1;
        drive_idle_inputs();
    endtask

    // Observe n cycles after E0 (#1 after each edge E1..En). Optionally
    // injects another request that edge E(inj_k+1) samples.
    task automatic collect(input int inj_k, input int jpx, input int jpy, input int jqx,
                           input int jqy, input int jp, input int ja, input int n,
                           output int lat, output int pulses, output int rx, output int ry,
                           output bit zero_ok);
        lat     = 0;
        pulses  = 0;
        rx      = -1;
        ry      = -1;
        zero_ok = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat = k;
                    rx  = int'(out_Rx);
                    ry  = int'(out_Ry);
                end
            end else if (out_Rx != '0 || out_Ry != '0) begin
                zero_ok = 1'b0;
            end
            if (k == inj_k) drive_req(jpx, jpy, jqx, jqy, jp, ja);
            if (k == inj_k + 1) drive_idle_inputs();
        end
    endtask

    task automatic test_reset();
        bit zero_ok;
        rst_n = 1'b0;
        drive_idle_inputs();
        #3;
        n_checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid got %0b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_Rx !== '0) $display("[TB] FAIL reset_rx got %0d want 0", out_Rx);
        else n_pass++;
        n_checks++;
        if (out_Ry !== '0) $display("[TB] FAIL reset_ry got %0d want 0", out_Ry);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        zero_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || out_Rx !== '0 || out_Ry !== '0) zero_ok = 1'b0;
        end
        n_checks++;
        if (!zero_ok) $display("[TB] FAIL reset_idle got nonzero outputs want 0/0/0");
        else n_pass++;
    endtask

    // Single request against hard expected values, with latency and framing checks
    task automatic test_vector(input string name, input int px, input int py, input int qx,
                               input int qy, input int p, input int a,
                               input int ex, input int ey);
        int  lat, pulses, rx, ry;
        bit  zero_ok;
        issue(px, py, qx, qy, p, a);
        collect(-10, 0, 0, 0, 0, 3, 0, 12, lat, pulses, rx, ry, zero_ok);
        n_checks++;
        if (lat != 10 || pulses != 1)
            $display("[TB] FAIL %s_timing got lat=%0d pulses=%0d want lat=10 pulses=1", name, lat, pulses);
        else n_pass++;
        n_checks++;
        if (rx != ex || ry != ey)
            $display("[TB] FAIL %s_result got (%0d,%0d) want (%0d,%0d)", name, rx, ry, ex, ey);
        else n_pass++;
        n_checks++;
        if (!zero_ok) $display("[TB] FAIL %s_zero got nonzero idle outputs want 0", name);
        else n_pass++;
    endtask

    task automatic test_add();
        test_vector("add", 5, 1, 6, 3, 17, 2, 10, 6);
    endtask

    task automatic test_double();
        test_vector("double", 5, 1, 5, 1, 17, 2, 6, 3);
    endtask

    task automatic test_infinity();
        test_vector("neg_inf", 5, 1, 5, 16, 17, 2, 0, 0);
        test_vector("dbl_inf", 3, 0, 3, 0, 17, 2, 0, 0);
    endtask

    task automatic test_busy_drop();
        int lat, pulses, rx, ry;
        bit zero_ok;
        issue(5, 1, 6, 3, 17, 2);
        collect(3, 5, 1, 5, 1, 17, 2, 16, lat, pulses, rx, ry, zero_ok);
        n_checks++;
        if (lat != 10 || pulses != 1)
            $display("[TB] FAIL busy_timing got lat=%0d pulses=%0d want lat=10 pulses=1", lat, pulses);
        else n_pass++;
        n_checks++;
        if (rx != 10 || ry != 6) $display("[TB] FAIL busy_result got (%0d,%0d) want (10,6)", rx, ry);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int lat, pulses, rx, ry;
        bit zero_ok;
        issue(5, 1, 6, 3, 17, 2);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_Rx !== '0 || out_Ry !== '0)
            $display("[TB] FAIL abort_clear got %0b/%0d/%0d want 0/0/0", out_valid, out_Rx, out_Ry);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        collect(-10, 0, 0, 0, 0, 3, 0, 12, lat, pulses, rx, ry, zero_ok);
        n_checks++;
        if (pulses != 0) $display("[TB] FAIL abort_no_pulse got pulses=%0d want 0", pulses);
        else n_pass++;
        test_vector("after_abort", 5, 1, 5, 1, 17, 2, 6, 3);
    endtask

    task automatic test_back_to_back();
        int lat, pulses, rx, ry;
        bit zero_ok;
        issue(5, 1, 6, 3, 17, 2);
        collect(11, 5, 1, 5, 1, 17, 2, 12, lat, pulses, rx, ry, zero_ok);
        n_checks++;
        if (lat != 10 || pulses != 1 || rx != 10 || ry != 6)
            $display("[TB] FAIL b2b_first got lat=%0d pulses=%0d (%0d,%0d) want 10 1 (10,6)", lat, pulses, rx, ry);
        else n_pass++;
        collect(-10, 0, 0, 0, 0, 3, 0, 12, lat, pulses, rx, ry, zero_ok);
        n_checks++;
        if (lat != 10 || pulses != 1 || rx != 6 || ry != 3)
            $display("[TB] FAIL b2b_second got lat=%0d pulses=%0d (%0d,%0d) want 10 1 (6,3)", lat, pulses, rx, ry);
        else n_pass++;
    endtask

    task automatic test_random(input int n_vec);
        int primes[17] = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61};
        int p, a, px, py, qx, qy, ex, ey, lat, pulses, rx, ry, sel;
        bit zero_ok;
        for (int v = 0; v < n_vec; v++) begin
            p   = primes[$urandom_range(0, 16)];
            a   = $urandom_range(0, p - 1);
            px  = $urandom_range(0, p - 1);
            py  = $urandom_range(0, p - 1);
            qx  = $urandom_range(0, p - 1);
            qy  = $urandom_range(0, p - 1);
            sel = $urandom_range(0, 7);
            if (sel < 2) begin
                qx = px;
                qy = py;
            end else if (sel == 2) begin
                qx = px;
                qy = md(-py, p);
            end
            ref_add(px, py, qx, qy, p, a, ex, ey);
            issue(px, py, qx, qy, p, a);
            collect(-10, 0, 0, 0, 0, 3, 0, 12, lat, pulses, rx, ry, zero_ok);
            n_checks++;
            if (lat != 10 || pulses != 1 || !zero_ok)
                $display("[TB] FAIL rand_timing v=%0d got lat=%0d pulses=%0d zero=%0b want 10 1 1",
                         v, lat, pulses, zero_ok);
            else n_pass++;
            n_checks++;
            if (rx != ex || ry != ey)
                $display("[TB] FAIL rand_result v=%0d p=%0d a=%0d P=(%0d,%0d) Q=(%0d,%0d) got (%0d,%0d) want (%0d,%0d)",
                         v, p, a, px, py, qx, qy, rx, ry, ex, ey);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_double();
        test_infinity();
        test_busy_drop();
        test_reset_abort();
        test_back_to_back();
        test_random(300);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
